// File: rtl/store_serializer_pkg.sv
// rtl/store_serializer_pkg.sv - shared types and helpers for the store serializer
package store_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } store_size_t;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    // Number of beats minus one for a store size; also the alignment mask.
    function automatic logic [2:0] last_beat_for_size(input store_size_t sz);
        case (sz)
            SZ_B:    return 3'd0;
            SZ_H:    return 3'd1;
            SZ_W:    return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/store_serializer_if.sv
// rtl/store_serializer_if.sv - request and byte-wide memory port bundle
interface store_serializer_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic [1:0]        req_size;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ready;
    logic              done;
    logic              busy;
    logic              misalign;

    // Environment side: issues store requests and acts as the memory.
    modport master (
        output req_valid, req_addr, req_data, req_size, mem_ready,
        input  req_ready, mem_wr_en, mem_addr, mem_wdata, done, busy, misalign
    );

    // Serializer side.
    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_ready,
        output req_ready, mem_wr_en, mem_addr, mem_wdata, done, busy, misalign
    );
endinterface

// File: rtl/store_serializer.sv
// rtl/store_serializer.sv - narrows a 64-bit store to byte/half/word/double and writes it one byte per beat, little-endian; optional ALIGN_CHECK_EN rejects misaligned stores
module store_serializer
    import store_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic               clk,
    input  logic               reset,
    store_serializer_if.slave  bus
);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          beats_q, beats_d;
    logic                done_q, done_d;
`ifdef ALIGN_CHECK_EN
    logic                misalign_q, misalign_d;
`endif

    logic       accept;
    logic [2:0] last_beat;

    assign last_beat = last_beat_for_size(store_size_t'(bus.req_size));
    // Gating with reset keeps req_ready low while reset is held and high in the first cycle after release.
    assign bus.req_ready = (state_q == IDLE) && reset;
    assign accept        = bus.req_valid && bus.req_ready;

    // Next-state, shift register and beat counter.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        addr_d     = addr_q;
        beats_d    = beats_q;
        done_d     = 1'b0;
`ifdef ALIGN_CHECK_EN
        misalign_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d  = bus.req_data;
                    addr_d  = bus.req_addr;
                    beats_d = last_beat;
`ifdef ALIGN_CHECK_EN
                    if ((bus.req_addr[2:0] & last_beat) != 3'd0) begin
                        done_d     = 1'b1;
                        misalign_d = 1'b1;
                    end else begin
                        state_d = XFER;
                    end
`else
                    state_d = XFER;
`endif
                end
            end
            XFER: begin
                if (bus.mem_ready) begin
                    data_d = data_q >> BYTE_W;
                    addr_d = addr_q + 1'b1;
                    if (beats_q == 3'd0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        beats_d = beats_q - 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All serializer state; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            data_q     <= '0;
            addr_q     <= '0;
            beats_q    <= '0;
            done_q     <= 1'b0;
`ifdef ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
            beats_q    <= beats_d;
            done_q     <= done_d;
`ifdef ALIGN_CHECK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign bus.mem_wr_en = (state_q == XFER);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = data_q[BYTE_W-1:0];
    assign bus.busy      = (state_q == XFER);
    assign bus.done      = done_q;
`ifdef ALIGN_CHECK_EN
    assign bus.misalign  = misalign_q;
`else
    assign bus.misalign  = 1'b0;
`endif

endmodule

// File: tb/tb_store_serializer.sv
// tb/tb_store_serializer.sv - directed scoreboard bench for store_serializer (ALIGN_CHECK_EN selects the misalign case)
module tb_store_serializer;
    import store_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    store_serializer_if bus ();

    store_serializer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  data;
    } beat_t;

    beat_t exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted beat must match the oldest expected beat.
    always @(negedge clk) begin
        if (reset === 1'b1 && bus.mem_wr_en === 1'b1 && bus.mem_ready === 1'b1) begin
            tests++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_beat observed_addr=%0h expected=no_beat", bus.mem_addr);
            end
            if (exp_q.size() != 0) begin
                beat_t b;
                b = exp_q.pop_front();
                chk("beat_addr", bus.mem_addr, b.addr);
                chk("beat_data", {56'd0, bus.mem_wdata}, {56'd0, b.data});
            end
        end
`ifndef ALIGN_CHECK_EN
        if (bus.misalign !== 1'b0) chk("misalign_tied", {63'd0, bus.misalign}, 64'd0);
`endif
    end

    task automatic push_beats(input logic [63:0] addr, input logic [63:0] data, input logic [1:0] size);
        int n;
        beat_t b;
        logic [63:0] d;
        n = 1 << size;
        for (int i = 0; i < n; i++) begin
            b.addr = addr + 64'(i);
            d      = data >> (8 * i);
            b.data = d[7:0];
            exp_q.push_back(b);
        end
    endtask

    // Drive one request just after a rising edge and let it be accepted on the next edge.
    task automatic issue(input logic [63:0] addr, input logic [63:0] data, input logic [1:0] size);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_data  = data;
        bus.req_size  = size;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.req_addr  = 64'h5555;
    endtask

    task automatic wait_done(input string tag, input int exp_cycles);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.done !== 1'b1 && k < 40);
        chk({tag, "_done"}, {63'd0, bus.done}, 64'd1);
        chk({tag, "_latency"}, 64'(k), 64'(exp_cycles));
        chk({tag, "_ready_at_done"}, {63'd0, bus.req_ready}, 64'd1);
        chk({tag, "_all_beats"}, 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, {63'd0, bus.done}, 64'd0);
    endtask

    initial begin
        bus.req_valid = 1'b1;
        bus.req_addr  = 64'h1234;
        bus.req_data  = 64'h1;
        bus.req_size  = 2'b11;
        bus.mem_ready = 1'b1;
        reset         = 1'b0;

        // 1: reset with a pending request
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd0);
        chk("rst_mem_wr_en", {63'd0, bus.mem_wr_en}, 64'd0);
        chk("rst_mem_addr", bus.mem_addr, 64'd0);
        chk("rst_mem_wdata", {56'd0, bus.mem_wdata}, 64'd0);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_misalign", {63'd0, bus.misalign}, 64'd0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        reset         = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {63'd0, bus.req_ready}, 64'd1);
        chk("post_rst_wr_en", {63'd0, bus.mem_wr_en}, 64'd0);
        @(posedge clk);
        #1;

        // 2: byte store
        push_beats(64'h100, 64'hDEADBEEF_CAFEF00D, 2'b00);
        issue(64'h100, 64'hDEADBEEF_CAFEF00D, 2'b00);
        wait_done("byte", 2);

        // 3: double store, busy during the transfer
        @(posedge clk);
        #1;
        push_beats(64'h200, 64'h0807060504030201, 2'b11);
        issue(64'h200, 64'h0807060504030201, 2'b11);
        chk("dbl_busy", {63'd0, bus.busy}, 64'd1);
        chk("dbl_not_ready", {63'd0, bus.req_ready}, 64'd0);
        wait_done("dbl", 9);

        // 4: half store with three stalled cycles on beat 0
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
        push_beats(64'h10, 64'hAABB, 2'b01);
        issue(64'h10, 64'hAABB, 2'b01);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_wr_en", {63'd0, bus.mem_wr_en}, 64'd1);
            chk("stall_addr", bus.mem_addr, 64'h10);
            chk("stall_wdata", {56'd0, bus.mem_wdata}, 64'hBB);
        end
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b1;
        wait_done("half", 3);

        // 5: word store across the address wrap, reset after two beats
        @(posedge clk);
        #1;
        push_beats(64'hFFFF_FFFF_FFFF_FFFE, 64'h44332211, 2'b01);
        issue(64'hFFFF_FFFF_FFFF_FFFE, 64'h44332211, 2'b10);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_wr_en", {63'd0, bus.mem_wr_en}, 64'd0);
        chk("abort_addr", bus.mem_addr, 64'd0);
        chk("abort_beats_seen", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_done", {63'd0, bus.done}, 64'd0);
            chk("abort_no_beat", {63'd0, bus.mem_wr_en}, 64'd0);
        end

        // 5b: full wrap without reset
        @(posedge clk);
        #1;
        push_beats(64'hFFFF_FFFF_FFFF_FFFE, 64'h44332211, 2'b10);
        issue(64'hFFFF_FFFF_FFFF_FFFE, 64'h44332211, 2'b10);
        wait_done("wrap", 5);

        // 6: misaligned word store
        @(posedge clk);
        #1;
`ifdef ALIGN_CHECK_EN
        issue(64'h3, 64'hA1B2C3D4, 2'b10);
        @(negedge clk);
        chk("mis_flag", {63'd0, bus.misalign}, 64'd1);
        chk("mis_done", {63'd0, bus.done}, 64'd1);
        chk("mis_no_beat", {63'd0, bus.mem_wr_en}, 64'd0);
        chk("mis_ready", {63'd0, bus.req_ready}, 64'd1);
        @(negedge clk);
        chk("mis_flag_clear", {63'd0, bus.misalign}, 64'd0);
        chk("mis_done_clear", {63'd0, bus.done}, 64'd0);
        chk("mis_still_no_beat", {63'd0, bus.mem_wr_en}, 64'd0);
`else
        push_beats(64'h3, 64'hA1B2C3D4, 2'b10);
        issue(64'h3, 64'hA1B2C3D4, 2'b10);
        wait_done("unaligned", 5);
`endif

        repeat (2) @(negedge clk);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/store_serializer.md
Name: store_serializer

Overview:
- Write-side counterpart to the load-path extenders in the 64-bit datapath.
- Takes a 64-bit register value and a store size (STURB/STURH/STURW/STUR): byte, half, word or double.
- Narrows the value to the requested width and writes it to an 8-bit-wide data memory port, one byte per accepted beat, little-endian.
- Sits between the execute/memory stage and the byte-wide memory model; uses a valid/ready handshake on both sides.

Parameters:
ADDR_W, 64, width of the request and memory byte addresses
DATA_W, 64, width of the register store data; fixed at 64, a multiple of 8 is required

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
req_valid  in  1  store request present
req_ready  out  1  serializer can accept a request
req_addr  in  ADDR_W  byte address of the least significant byte
req_data  in  DATA_W  register value; only the low (8 << req_size) bits are stored
req_size  in  2  00 byte, 01 half, 10 word, 11 double
mem_wr_en  out  1  byte write beat valid
mem_addr  out  ADDR_W  byte address of the current beat
mem_wdata  out  8  byte being written
mem_ready  in  1  memory accepts the beat this cycle
done  out  1  one-cycle pulse after the final beat is accepted
busy  out  1  request in progress
misalign  out  1  one-cycle pulse on an alignment fault (ALIGN_CHECK_EN only; otherwise tied 0)

Behaviour:
- Reset (asynchronous, while reset==0): state IDLE, data/address/count registers cleared.
  - Outputs during reset: req_ready=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, done=0, busy=0, misalign=0.
  - First cycle after release: req_ready=1.
- States: IDLE, XFER.
- IDLE:
  - req_ready=1, busy=0, mem_wr_en=0.
  - Request accepted when req_valid&&req_ready. On that edge:
    - latch data=req_data, addr=req_addr, beats_left=(1<<req_size)-1;
    - go to XFER.
- XFER:
  - req_ready=0, busy=1, mem_wr_en=1, mem_wdata=data[7:0], mem_addr=addr.
  - On mem_ready=1:
    - data shifts right 8 (zero fill), addr increments by 1;
    - if beats_left==0: go to IDLE and pulse done=1 in the next cycle (registered);
    - otherwise beats_left decrements.
  - On mem_ready=0: all registers hold; mem_addr and mem_wdata stay stable.
- Latency:
  - First beat is presented the cycle after acceptance.
  - Best case, a store of N bytes occupies N cycles in XFER.
  - done is asserted in the cycle req_ready returns to 1.
  - Next request can be accepted in that same done cycle, giving back-to-back throughput of N+1 cycles per store.
- Bits of req_data above the store width are never written. Bit 63 is not inspected; there is no sign handling.
- Address arithmetic is modulo 2^ADDR_W: 0xFFFF_FFFF_FFFF_FFFF + 1 wraps to 0 with no flag.
- Changes on req_* while busy are ignored.
- Reset mid-XFER aborts immediately: no further beats and no done pulse.

Optional Feature:
- Macro: ALIGN_CHECK_EN.
- Defined:
  - A request whose address is not aligned to its size is accepted but produces no memory beats. Misaligned means req_addr & ((1<<req_size)-1) != 0.
  - Next cycle: misalign=1 and done=1 for exactly one cycle, state IDLE.
  - Byte stores are always aligned.
- Undefined:
  - misalign tied 0.
  - Misaligned stores are serialized normally from req_addr upward.

Decomposition:
- Package store_pkg holds:
  - enum store_size_t {SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10, SZ_D=2'b11};
  - enum state_t {IDLE, XFER};
  - localparam BYTE_W=8.
- Single flat module; no sub-module is natural. The shift register and counter are a few lines each.

Test Plan:
1. Reset held low while req_valid=1 -> all outputs 0. After release req_ready=1 and no mem_wr_en.
2. Byte store, addr=0x100, data=0xDEADBEEF_CAFEF00D, mem_ready=1 -> one beat (0x100, 0x0D). done pulses 2 cycles after accept.
3. Double store, addr=0x200, data=0x0807060504030201, mem_ready=1 -> 8 consecutive beats at 0x200..0x207 carrying bytes 01..08, then done.
4. Half store, addr=0x10, data=0xAABB, mem_ready low for 3 cycles on beat 0 -> mem_addr=0x10 and mem_wdata=0xBB stable throughout; then beat (0x11, 0xAA), then done.
5. Word store at addr=0xFFFF_FFFF_FFFF_FFFE -> beats at ...FE, ...FF, 0x0, 0x1 (wrap). Reset asserted after beat 2 -> no further beats, no done.
6. ALIGN_CHECK_EN defined, word store at addr=0x3 -> zero mem_wr_en cycles, misalign=1 and done=1 together for one cycle. Undefined -> 4 beats at 0x3..0x6.
